// File: rtl/decoder_38_scan_if.sv
// Switch/LED bundle between the decoder and whatever drives its code inputs.
// Master drives din/en/load/scan/dir; slave returns dout/code/valid.
interface decoder_38_scan_if;
   logic [2:0] din;
   logic       en;
   logic       load;
   logic       scan;
   logic       dir;
   logic [7:0] dout;
   logic [2:0] code;
   logic       valid;

   modport master (output din, en, load, scan, dir, input dout, code, valid);
   modport slave  (input din, en, load, scan, dir, output dout, code, valid);
endinterface

// File: rtl/decoder_38_scan.sv
// Registered 3-to-8 one-hot decoder with load latch and prescaled auto-scan.
// Latency: one edge from any sampled input to dout/code/valid.
// No backpressure: level inputs are sampled every edge, outputs always live.
module decoder_38_scan #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int ACTIVE_LOW = 0
) (
   input  logic clk,
   input  logic rst,
   decoder_38_scan_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST  = PW'(TICK_DIV - 1);
   localparam logic [7:0]    BLANK = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

   state_t        state;
   logic [2:0]    code_q;
   logic [PW-1:0] pre;
   logic [7:0]    dout_q;
   logic          valid_q;
   logic          tick;
   logic [2:0]    code_step;

   function automatic logic [7:0] shown(input logic [2:0] c);
      logic [7:0] oh;
      oh = 8'h01 << c;
      return (ACTIVE_LOW != 0) ? ~oh : oh;
   endfunction

   assign tick      = (pre == LAST);
   assign code_step = bus.dir ? (code_q - 3'd1) : (code_q + 3'd1);

   // dout/valid are loaded from the same next-state decisions as state/code,
   // so all outputs move together on one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         code_q  <= 3'd0;
         pre     <= '0;
         dout_q  <= BLANK;
         valid_q <= 1'b0;
      end else if (!bus.en) begin
         state   <= IDLE;
         pre     <= '0;
         dout_q  <= BLANK;
         valid_q <= 1'b0;
      end else if (bus.load) begin
         state   <= HOLD;
         code_q  <= bus.din;
         pre     <= '0;
         dout_q  <= shown(bus.din);
         valid_q <= 1'b1;
      end else if (bus.scan) begin
         state   <= SCAN;
         valid_q <= 1'b1;
         if (state != SCAN) begin
            pre    <= '0;
            dout_q <= shown(code_q);
         end else if (tick) begin
            pre    <= '0;
            code_q <= code_step;
            dout_q <= shown(code_step);
         end else begin
            pre    <= pre + 1'b1;
            dout_q <= shown(code_q);
         end
      end else if (state == SCAN) begin
         state   <= HOLD;
         pre     <= '0;
         dout_q  <= shown(code_q);
         valid_q <= 1'b1;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.code  = code_q;
   assign bus.valid = valid_q;
endmodule

// File: tb/tb_decoder_38_scan.sv
// Bench: three decoder variants share one stimulus stream and are checked
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_decoder_38_scan;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] din = 3'd0;
   logic en = 1'b0, load = 1'b0, scan = 1'b0, dir = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;
   bit run_chk = 1'b0;

   always #5 clk = ~clk;

   decoder_38_scan_if ifa ();
   decoder_38_scan_if ifb ();
   decoder_38_scan_if ifc ();

   assign ifa.din = din;  assign ifa.en = en;  assign ifa.load = load;
   assign ifa.scan = scan; assign ifa.dir = dir;
   assign ifb.din = din;  assign ifb.en = en;  assign ifb.load = load;
   assign ifb.scan = scan; assign ifb.dir = dir;
   assign ifc.din = din;  assign ifc.en = en;  assign ifc.load = load;
   assign ifc.scan = scan; assign ifc.dir = dir;

   decoder_38_scan #(.TICK_DIV(4), .ACTIVE_LOW(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   decoder_38_scan #(.TICK_DIV(4), .ACTIVE_LOW(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
   decoder_38_scan #(.TICK_DIV(1), .ACTIVE_LOW(0)) u_c (.clk(clk), .rst(rst), .bus(ifc));

   // Model: mode 0=blank, 1=frozen, 2=scanning; cnt = edges since last step.
   int td [3] = '{4, 4, 1};
   int al [3] = '{0, 1, 0};
   int m_mode [3] = '{0, 0, 0};
   int m_code [3] = '{0, 0, 0};
   int m_cnt  [3] = '{0, 0, 0};

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_mode[i] <= 0; m_code[i] <= 0; m_cnt[i] <= 0;
         end else if (!en) begin
            m_mode[i] <= 0; m_cnt[i] <= 0;
         end else if (load) begin
            m_mode[i] <= 1; m_code[i] <= int'(din); m_cnt[i] <= 0;
         end else if (scan) begin
            m_mode[i] <= 2;
            if (m_mode[i] != 2) m_cnt[i] <= 0;
            else if (m_cnt[i] + 1 == td[i]) begin
               m_cnt[i]  <= 0;
               m_code[i] <= (m_code[i] + (dir ? 7 : 1)) % 8;
            end else m_cnt[i] <= m_cnt[i] + 1;
         end else if (m_mode[i] == 2) begin
            m_mode[i] <= 1; m_cnt[i] <= 0;
         end
      end
   end

   function automatic int exp_dout(int i);
      int v;
      v = (m_mode[i] == 0) ? 0 : (1 << m_code[i]);
      return (al[i] != 0) ? (v ^ 255) : v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (run_chk) begin
         chk("a.dout",  int'(ifa.dout),  exp_dout(0));
         chk("a.code",  int'(ifa.code),  m_code[0]);
         chk("a.valid", int'(ifa.valid), int'(m_mode[0] != 0));
         chk("b.dout",  int'(ifb.dout),  exp_dout(1));
         chk("b.code",  int'(ifb.code),  m_code[1]);
         chk("b.valid", int'(ifb.valid), int'(m_mode[1] != 0));
         chk("c.dout",  int'(ifc.dout),  exp_dout(2));
         chk("c.code",  int'(ifc.code),  m_code[2]);
         chk("c.valid", int'(ifc.valid), int'(m_mode[2] != 0));
      end
   end

   task automatic cyc(input int n = 1);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   logic [7:0] onehot [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      // Reset and blank
      cyc(1);
      run_chk = 1'b1;
      cyc(1);
      rst = 1'b0; en = 1'b1;
      cyc(1);
      chk("rst a.dout", int'(ifa.dout), 'h00);
      chk("rst a.code", int'(ifa.code), 0);
      chk("rst a.valid", int'(ifa.valid), 0);
      chk("rst b.dout", int'(ifb.dout), 'hFF);

      // Load every code; held load re-latches each edge
      load = 1'b1;
      for (int d = 0; d < 8; d++) begin
         din = 3'(d);
         cyc(1);
         chk("load a.dout", int'(ifa.dout), int'(onehot[d]));
         chk("load a.valid", int'(ifa.valid), 1);
      end
      load = 1'b0; din = 3'd2;
      cyc(2);
      chk("frozen a.code", int'(ifa.code), 7);
      chk("frozen b.dout", int'(ifb.dout), 'h7F);

      // Scan up with wrap 6,7,0,1
      din = 3'd6; load = 1'b1; cyc(1);
      load = 1'b0; scan = 1'b1; dir = 1'b0;
      cyc(1); chk("up entry", int'(ifa.code), 6);
      cyc(3); chk("up hold4", int'(ifa.code), 6);
      cyc(1); chk("up step7", int'(ifa.code), 7);
      cyc(4); chk("up wrap0", int'(ifa.code), 0);
      cyc(4); chk("up step1", int'(ifa.code), 1);
      scan = 1'b0; cyc(1);
      chk("up stop dout", int'(ifa.dout), 'h02);
      chk("up stop valid", int'(ifa.valid), 1);

      // Scan down with wrap, then dir flip mid-scan
      scan = 1'b1; dir = 1'b1;
      cyc(1); chk("dn entry", int'(ifa.code), 1);
      cyc(4); chk("dn step0", int'(ifa.code), 0);
      cyc(4); chk("dn wrap7", int'(ifa.code), 7);
      dir = 1'b0;
      cyc(4); chk("flip step0", int'(ifa.code), 0);

      // Priority: load beats scan; en drop mid-scan
      din = 3'd3; load = 1'b1; cyc(1);
      chk("prio dout", int'(ifa.dout), 'h08);
      load = 1'b0;
      cyc(9); chk("scan to 5", int'(ifa.code), 5);
      en = 1'b0; cyc(1);
      chk("en0 dout", int'(ifa.dout), 'h00);
      chk("en0 valid", int'(ifa.valid), 0);
      chk("en0 code", int'(ifa.code), 5);
      chk("en0 b.dout", int'(ifb.dout), 'hFF);
      en = 1'b1; scan = 1'b0; cyc(1);
      chk("idle code", int'(ifa.code), 5);
      scan = 1'b1; cyc(1);
      chk("rescan code", int'(ifa.code), 5);
      chk("rescan dout", int'(ifa.dout), 'h20);

      // TICK_DIV=1 steps every edge, then reset mid-scan
      scan = 1'b0; din = 3'd0; load = 1'b1; cyc(1);
      load = 1'b0; scan = 1'b1;
      cyc(1); chk("td1 entry", int'(ifc.code), 0);
      cyc(1); chk("td1 s1", int'(ifc.code), 1);
      cyc(1); chk("td1 s2", int'(ifc.code), 2);
      cyc(1); chk("td1 s3", int'(ifc.code), 3);
      rst = 1'b1; cyc(1);
      chk("midrst code", int'(ifc.code), 0);
      chk("midrst dout", int'(ifc.dout), 'h00);
      chk("midrst valid", int'(ifc.valid), 0);
      chk("midrst b.dout", int'(ifb.dout), 'hFF);
      rst = 1'b0; scan = 1'b0;
      cyc(2);
      run_chk = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/decoder_38_scan.md
Name: decoder_38_scan

Overview:
- Registered 3-to-8 one-hot decoder with a latch and an auto-scan mode; the inverse of our 8-3 priority encoder.
- Drives the 8-LED bank (LD7-LD0) from a 3-bit code, either supplied on switches (SW2-SW0) or generated by an internal stepping counter.
- Acts as the companion block for the encoder labs: encoder output fed back into `din` must light exactly the LED of the highest set switch.

Parameters:
- TICK_DIV, 50_000_000: clock cycles per scan step. Legal range is 1 or more. A value of 1 means one step per clock.
- ACTIVE_LOW, 0: 0 gives active-high `dout`; 1 gives active-low `dout` (all bits inverted, including the blank value).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  3  code to load (SW2-SW0).
- en  input  1  block enable. When 0, the outputs are blanked.
- load  input  1  latch `din` into the code register. Level-sampled on every edge.
- scan  input  1  request auto-scan mode. Level-sensitive.
- dir  input  1  scan direction: 0 counts up, 1 counts down.
- dout  output  8  one-hot decode of `code`, with polarity set by ACTIVE_LOW (LD7-LD0).
- code  output  3  current code register.
- valid  output  1  1 when `dout` is showing a code (state HOLD or SCAN).

Behaviour:
- Reset (rst=1 at an edge, overrides every other input):
  - state=IDLE, code=0, prescaler=0, valid=0.
  - dout=8'h00 when ACTIVE_LOW=0; dout=8'hFF when ACTIVE_LOW=1.
- Registers: state, code, prescaler, dout and valid are all flops. `dout` and `valid` are registered from the next-state values, so they change on the same edge as `state` and `code`. Latency from a sampled input to every output is 1 edge; nothing is combinational from input to output.
- States are IDLE, HOLD and SCAN. Transitions are evaluated each edge in this priority order:
  1. en=0 -> IDLE. `code` is retained.
  2. load=1 -> HOLD, and code<=din. Load wins over scan when both are asserted.
  3. scan=1 -> SCAN, starting from the current `code`.
  4. state=SCAN and scan=0 -> HOLD, freezing `code` at its current value.
  5. Otherwise the state is unchanged. IDLE with en=1 and no load/scan stays IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in SCAN.
  - tick=1 on the edge where the count equals TICK_DIV-1; the count then wraps to 0.
  - Cleared to 0 on every entry into SCAN and on every load.
  - In states other than SCAN, the prescaler holds 0.
- Scan stepping:
  - On a tick in SCAN, code<=code+1 when dir=0 and code<=code-1 when dir=1, modulo 8.
  - Wrap-around: 7->0 counting up, 0->7 counting down.
  - The first step occurs TICK_DIV edges after SCAN is entered.
  - A change of `dir` mid-scan takes effect at the next tick and does not clear the prescaler.
- Decode: in HOLD or SCAN, dout[k]=1 exactly when k==code; in IDLE, dout is all-zero. When ACTIVE_LOW=1, the whole vector is inverted.
- valid = (next_state != IDLE), registered.
- Boundary cases:
  - load during SCAN leaves SCAN immediately and shows `din` at the next edge.
  - A held `load` level keeps re-latching `din` each edge, so `din` changes are tracked.
  - en dropping mid-scan blanks the outputs at the next edge. When en returns, the block re-enters IDLE and `code` is preserved for a later scan.
  - rst asserted mid-scan clears everything at that edge, regardless of tick.
- Width rules: the prescaler is $clog2(TICK_DIV) bits wide, minimum 1 bit. The code arithmetic is 3-bit unsigned with natural wrap.

Test Plan:
- Reset and blank: rst=1 for 2 edges, then en=1 with load/scan=0 -> dout=00, code=0, valid=0. With ACTIVE_LOW=1 the same stimulus gives dout=FF.
- Load all codes: en=1, load=1 for one cycle per code with din=0..7 -> one edge later dout=01,02,04,...,80 and valid=1. Code stays frozen after load is released.
- Scan up with wrap (TICK_DIV=4): load din=6, then scan=1, dir=0 -> code 6 for 4 edges, then 7, then 0, then 1, stepping every 4 edges. Dropping scan at code=1 gives HOLD with dout=02.
- Scan down with wrap plus mid-scan dir flip (TICK_DIV=4): start at code 1 with dir=1 -> sequence 1,0,7. Set dir=0 at code 7 -> next tick gives 0, with no extra delay.
- Priority: load=1 and scan=1 together with din=3 -> HOLD, dout=08. en=0 during SCAN at code 5 -> next edge dout=00, valid=0, code=5 retained.
- TICK_DIV=1 and reset mid-scan: TICK_DIV=1 scan steps code every edge (0,1,2,...). Asserting rst during this scan gives code=0, dout=00, valid=0 at that edge.
